// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the two-requester data-RAM arbiter.
package ram_arb_pkg;

  typedef enum logic {
    ST_FREE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 64;

endpackage

// File: rtl/ram_arb_rr.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the
// requester that was not granted last.
module ram_arb_rr (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter/sequencer sharing one single-port data RAM between fetch (req 0)
// and load/store (req 1), with registered read return and a bounded lock.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int LOCK_MAX = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  input  logic [1:0]      lock,
  input  logic [1:0]      we,
  input  logic [2*AW-1:0] adr,
  input  logic [2*DW-1:0] wdata,
  output logic [1:0]      gnt,
  output logic [1:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic [1:0]      lock_abort,
  output logic [AW-1:0]   ram_adr,
  output logic [DW-1:0]   ram_writeData,
  output logic            ram_writeEn,
  input  logic [DW-1:0]   ram_readData
);

  localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

  arb_state_t     state_reg, state_next;
  logic           owner_reg, owner_next;
  logic           last_reg, last_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [1:0]     abort_reg, abort_next;
  logic [1:0]     rvalid_reg;
  logic [DW-1:0]  rdata_reg;
  logic [1:0]     rr_gnt;
  logic [1:0]     gnt_int;
  logic           gnt_idx;
  logic [AW-1:0]  adr_sel   [2];
  logic [DW-1:0]  wdata_sel [2];

  ram_arb_rr u_rr (
    .req  (req),
    .last (last_reg),
    .gnt  (rr_gnt)
  );

  // Grant selection and FSM next-state.
  always_comb begin
    gnt_int    = 2'b00;
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    abort_next = 2'b00;

    if (!rst) begin
      if (state_reg == ST_FREE) begin
        gnt_int = rr_gnt;
      end else begin
        gnt_int[owner_reg] = req[owner_reg];
      end
    end

    gnt_idx = gnt_int[1];
    if (|gnt_int) begin
      last_next = gnt_idx;
    end

    unique case (state_reg)
      ST_FREE: begin
        if (|gnt_int && lock[gnt_idx]) begin
          state_next = ST_LOCKED;
          owner_next = gnt_idx;
          cnt_next   = '0;
        end
      end
      ST_LOCKED: begin
        cnt_next = cnt_reg + 1'b1;
        if (gnt_int[owner_reg] && !lock[owner_reg]) begin
          state_next = ST_FREE;
        end else if (cnt_reg == CNT_LAST) begin
          // Forced release: owner loses the tie on the next contested cycle.
          state_next            = ST_FREE;
          abort_next[owner_reg] = 1'b1;
          last_next             = owner_reg;
        end
      end
      default: state_next = ST_FREE;
    endcase
  end

  // RAM mux: each requester contributes only when it holds the grant.
  for (genvar gi = 0; gi < 2; gi++) begin : g_mux
    assign adr_sel[gi]   = gnt_int[gi] ? adr[gi*AW +: AW]   : '0;
    assign wdata_sel[gi] = gnt_int[gi] ? wdata[gi*DW +: DW] : '0;
  end

  assign ram_adr       = adr_sel[0] | adr_sel[1];
  assign ram_writeData = wdata_sel[0] | wdata_sel[1];
  assign ram_writeEn   = |(gnt_int & we);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_FREE;
      owner_reg  <= 1'b0;
      last_reg   <= 1'b1;
      cnt_reg    <= '0;
      abort_reg  <= 2'b00;
      rvalid_reg <= 2'b00;
      rdata_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      last_reg   <= last_next;
      cnt_reg    <= cnt_next;
      abort_reg  <= abort_next;
      rvalid_reg <= gnt_int & ~we;
      if (|(gnt_int & ~we)) begin
        rdata_reg <= ram_readData;
      end
    end
  end

  assign gnt        = gnt_int;
  assign rvalid     = rvalid_reg;
  assign rdata      = rdata_reg;
  assign lock_abort = abort_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM (unwritten words read
// as 64'hA000_0000_0000_00xx where xx is the low address byte).
module tb_ram_arbiter;
  localparam int AW = 16;
  localparam int DW = 64;

  logic            clk;
  logic            rst;
  logic [1:0]      req, lock, we;
  logic [2*AW-1:0] adr;
  logic [2*DW-1:0] wdata;
  logic [1:0]      gnt, rvalid, lock_abort;
  logic [DW-1:0]   rdata;
  logic [AW-1:0]   ram_adr;
  logic [DW-1:0]   ram_writeData;
  logic            ram_writeEn;
  logic [DW-1:0]   ram_readData;

  int checks = 0;
  int passes = 0;

  logic [DW-1:0] mem     [256];
  logic          written [256];

  ram_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .lock          (lock),
    .we            (we),
    .adr           (adr),
    .wdata         (wdata),
    .gnt           (gnt),
    .rvalid        (rvalid),
    .rdata         (rdata),
    .lock_abort    (lock_abort),
    .ram_adr       (ram_adr),
    .ram_writeData (ram_writeData),
    .ram_writeEn   (ram_writeEn),
    .ram_readData  (ram_readData)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (ram_writeEn) begin
      mem[ram_adr[7:0]]     <= ram_writeData;
      written[ram_adr[7:0]] <= 1'b1;
    end
  end

  assign ram_readData = written[ram_adr[7:0]] === 1'b1 ? mem[ram_adr[7:0]]
                        : {56'hA0_0000_0000_0000, ram_adr[7:0]};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive(input logic rs, input logic [1:0] r, input logic [1:0] l,
                       input logic [1:0] w, input logic [15:0] a0, input logic [15:0] a1,
                       input logic [63:0] d0, input logic [63:0] d1);
    @(negedge clk);
    rst   = rs;
    req   = r;
    lock  = l;
    we    = w;
    adr   = {a1, a0};
    wdata = {d1, d0};
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) written[i] = 1'b0;
    rst = 1'b1; req = 2'b00; lock = 2'b00; we = 2'b00; adr = '0; wdata = '0;
    repeat (3) @(posedge clk);

    // Reset: grants gated even with write requests pending
    drive(1, 2'b11, 2'b00, 2'b11, 16'd3, 16'd7, 64'h1, 64'h2);
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_we", 64'(ram_writeEn), 64'h0);
    tick();
    chk("rst_rvalid", 64'(rvalid), 64'h0);
    chk("rst_rdata", rdata, 64'h0);
    chk("rst_abort", 64'(lock_abort), 64'h0);

    // Tie after reset: req0 first, then req1
    drive(0, 2'b11, 2'b00, 2'b00, 16'd3, 16'd7, 64'h0, 64'h0);
    chk("tie_gnt0", 64'(gnt), 64'h1);
    chk("tie_adr0", 64'(ram_adr), 64'd3);
    tick();
    chk("tie_rvalid0", 64'(rvalid), 64'h1);
    chk("tie_rdata0", rdata, 64'hA000_0000_0000_0003);
    drive(0, 2'b10, 2'b00, 2'b00, 16'd3, 16'd7, 64'h0, 64'h0);
    chk("tie_gnt1", 64'(gnt), 64'h2);
    chk("tie_adr1", 64'(ram_adr), 64'd7);
    tick();
    chk("tie_rvalid1", 64'(rvalid), 64'h2);
    chk("tie_rdata1", rdata, 64'hA000_0000_0000_0007);
    drive(0, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0, 64'h0, 64'h0);
    chk("gap_gnt", 64'(gnt), 64'h0);
    tick();
    chk("gap_rvalid", 64'(rvalid), 64'h0);
    chk("gap_rdata", rdata, 64'hA000_0000_0000_0007);

    // Write then read back
    drive(0, 2'b01, 2'b00, 2'b01, 16'd5, 16'd0, 64'hDEAD, 64'h0);
    chk("wr_gnt", 64'(gnt), 64'h1);
    chk("wr_en", 64'(ram_writeEn), 64'h1);
    chk("wr_adr", 64'(ram_adr), 64'd5);
    chk("wr_data", ram_writeData, 64'hDEAD);
    tick();
    chk("wr_rvalid", 64'(rvalid), 64'h0);
    drive(0, 2'b01, 2'b00, 2'b00, 16'd5, 16'd0, 64'h0, 64'h0);
    chk("rb_gnt", 64'(gnt), 64'h1);
    chk("rb_we", 64'(ram_writeEn), 64'h0);
    tick();
    chk("rb_rvalid", 64'(rvalid), 64'h1);
    chk("rb_rdata", rdata, 64'hDEAD);

    // Lock held by req0 for three accesses, released on the fourth
    drive(0, 2'b01, 2'b01, 2'b00, 16'd1, 16'd2, 64'h0, 64'h0);
    chk("lk_gnt_a", 64'(gnt), 64'h1);
    tick();
    chk("lk_rdata_a", rdata, 64'hA000_0000_0000_0001);
    for (int i = 0; i < 2; i++) begin
      drive(0, 2'b11, 2'b01, 2'b00, 16'd1, 16'd2, 64'h0, 64'h0);
      chk("lk_gnt_hold", 64'(gnt), 64'h1);
      tick();
      chk("lk_abort_hold", 64'(lock_abort), 64'h0);
    end
    drive(0, 2'b11, 2'b00, 2'b00, 16'd1, 16'd2, 64'h0, 64'h0);
    chk("lk_gnt_rel", 64'(gnt), 64'h1);
    tick();
    drive(0, 2'b11, 2'b00, 2'b00, 16'd1, 16'd2, 64'h0, 64'h0);
    chk("lk_gnt_after", 64'(gnt), 64'h2);
    tick();
    chk("lk_rvalid_after", 64'(rvalid), 64'h2);
    chk("lk_rdata_after", rdata, 64'hA000_0000_0000_0002);

    // Lock timeout with LOCK_MAX=4
    drive(0, 2'b01, 2'b01, 2'b00, 16'd11, 16'd12, 64'h0, 64'h0);
    chk("ab_gnt_enter", 64'(gnt), 64'h1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 2'b11, 2'b01, 2'b00, 16'd11, 16'd12, 64'h0, 64'h0);
      chk("ab_gnt_locked", 64'(gnt), 64'h1);
      tick();
      chk("ab_abort", 64'(lock_abort), (i == 3) ? 64'h1 : 64'h0);
    end
    drive(0, 2'b11, 2'b01, 2'b00, 16'd11, 16'd12, 64'h0, 64'h0);
    chk("ab_gnt_other", 64'(gnt), 64'h2);
    tick();
    chk("ab_abort_clear", 64'(lock_abort), 64'h0);
    chk("ab_rdata", rdata, 64'hA000_0000_0000_000C);

    // Reset while locked with a read pending
    drive(0, 2'b01, 2'b01, 2'b00, 16'd9, 16'd0, 64'h0, 64'h0);
    chk("rl_gnt", 64'(gnt), 64'h1);
    tick();
    chk("rl_rvalid", 64'(rvalid), 64'h1);
    drive(1, 2'b11, 2'b01, 2'b11, 16'd9, 16'd8, 64'h55, 64'h66);
    chk("rl_gnt_rst", 64'(gnt), 64'h0);
    chk("rl_we_rst", 64'(ram_writeEn), 64'h0);
    tick();
    chk("rl_rvalid_rst", 64'(rvalid), 64'h0);
    chk("rl_rdata_rst", rdata, 64'h0);
    drive(0, 2'b11, 2'b00, 2'b00, 16'd3, 16'd7, 64'h0, 64'h0);
    chk("rl_gnt_post", 64'(gnt), 64'h1);
    tick();
    chk("rl_rdata_post", rdata, 64'hA000_0000_0000_0003);

    // Ten idle cycles
    for (int i = 0; i < 10; i++) begin
      drive(0, 2'b00, 2'b00, 2'b11, 16'd4, 16'd6, 64'h77, 64'h88);
      chk("idle_gnt", 64'(gnt), 64'h0);
      chk("idle_we", 64'(ram_writeEn), 64'h0);
      chk("idle_adr", 64'(ram_adr), 64'h0);
      tick();
      chk("idle_rvalid", 64'(rvalid), 64'h0);
      chk("idle_rdata", rdata, 64'hA000_0000_0000_0003);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
